// File: rtl/perf_event_counter.sv
// Performance-monitor counter bank: NUM_CH event counters plus a cycle counter,
// with snapshot bank, sticky overflow and a 1-cycle read port. Optional threshold flags under PERF_THRESH_EN.
module perf_event_counter #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32,
  parameter int SAT_MODE = 0,
  localparam int SEL_W   = $clog2(NUM_CH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [NUM_CH-1:0] evt_i,
  input  logic              snap_i,
  input  logic              rd_req_i,
  input  logic [SEL_W-1:0]  rd_sel_i,
  input  logic              rd_snap_i,
  input  logic [CNT_W-1:0]  thresh_i,
  output logic              rd_valid_o,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic [NUM_CH:0]   ovf_o,
  output logic [NUM_CH-1:0] thr_hit_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Index NUM_CH is the cycle counter; it sees a constant-1 event.
  logic [CNT_W-1:0] cnt_q   [NUM_CH+1];
  logic [CNT_W-1:0] snap_q  [NUM_CH+1];
  logic [CNT_W-1:0] cnt_inc [NUM_CH+1];
  logic [NUM_CH:0]  inc;
  logic [NUM_CH:0]  at_max;
  logic [NUM_CH:0]  ovf_q;

  always_comb begin
    inc = {(NUM_CH + 1){en_i}} & {1'b1, evt_i};
    for (int k = 0; k <= NUM_CH; k++) begin
      at_max[k]  = (cnt_q[k] == CNT_MAX);
      cnt_inc[k] = at_max[k] ? ((SAT_MODE != 0) ? CNT_MAX : '0) : cnt_q[k] + CNT_W'(1);
    end
  end

  // Snapshot captures pre-edge values, so it is independent of clear and increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k <= NUM_CH; k++) begin
        cnt_q[k]  <= '0;
        snap_q[k] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int k = 0; k <= NUM_CH; k++) begin
        if (snap_i) snap_q[k] <= cnt_q[k];
        if (clr_i) begin
          cnt_q[k] <= '0;
          ovf_q[k] <= 1'b0;
        end else if (inc[k]) begin
          cnt_q[k] <= cnt_inc[k];
          if (at_max[k]) ovf_q[k] <= 1'b1;
        end
      end
    end
  end

  assign ovf_o = ovf_q;

  // Read port: valid-only, no ready. A request sampled on an edge returns the
  // pre-edge register value with rd_valid_o high for exactly the following cycle.
  logic             sel_ok;
  logic [CNT_W-1:0] rd_word;
  logic             rd_valid_q;
  logic [CNT_W-1:0] rd_data_q;

  always_comb begin
    sel_ok  = (rd_sel_i <= SEL_W'(NUM_CH));
    rd_word = '0;
    if (sel_ok) rd_word = rd_snap_i ? snap_q[rd_sel_i] : cnt_q[rd_sel_i];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_req_i;
      if (rd_req_i) rd_data_q <= rd_word;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

`ifdef PERF_THRESH_EN
  logic [NUM_CH-1:0] thr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      thr_q <= '0;
    end else if (clr_i) begin
      thr_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (inc[k] && (thresh_i != '0) && (cnt_inc[k] >= thresh_i)) thr_q[k] <= 1'b1;
      end
    end
  end

  assign thr_hit_o = thr_q;
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh_i;
  assign thr_hit_o     = '0;
`endif

endmodule
